// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;

   localparam int unsigned N_CLIENTS = 8;
   localparam int unsigned IDX_W     = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/arbiter_8way_dmux.sv
// 1-to-8 demultiplexer: routes `in` to the output selected by `sel`, others 0.
module DMux8Way (
   input  logic       in,
   input  logic [2:0] sel,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       e,
   output logic       f,
   output logic       g,
   output logic       h
);

   assign a = in & (sel == 3'd0);
   assign b = in & (sel == 3'd1);
   assign c = in & (sel == 3'd2);
   assign d = in & (sel == 3'd3);
   assign e = in & (sel == 3'd4);
   assign f = in & (sel == 3'd5);
   assign g = in & (sel == 3'd6);
   assign h = in & (sel == 3'd7);

endmodule

// File: rtl/arbiter_8way.sv
// Round-robin arbiter for 8 clients with grant hold and optional hold-limit revocation.
// One-hot grant is decoded from the registered owner index, so req never reaches outputs.
module arbiter_8way
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CLIENTS-1:0] req,
   output logic [N_CLIENTS-1:0] gnt,
   output logic [IDX_W-1:0]     gnt_idx,
   output logic                 gnt_valid,
   output logic                 timeout
);

   localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
   localparam logic HOLD_EN = (MAX_HOLD != 0);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;

   logic [IDX_W-1:0] win_c;
   logic             any_req_c;
   logic             own_req_c;
   logic             expire_c;

   // First set request at or above ptr, wrapping 7 -> 0.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_CLIENTS-1:0] r,
                                                input logic [IDX_W-1:0]     p);
      logic [IDX_W-1:0] pick;
      logic [IDX_W-1:0] cand;
      logic             found;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_CLIENTS; i++) begin
         cand = p + IDX_W'(i);
         if (!found && r[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign win_c     = rr_pick(req, ptr_q);
   assign any_req_c = |req;
   assign own_req_c = req[idx_q];
   assign expire_c  = HOLD_EN && (cnt_q == HOLD_LIM);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (any_req_c) state_d = GRANT;
         end
         GRANT: begin
            if (!own_req_c || expire_c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered-output and datapath next values.
   always_comb begin
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_req_c) begin
               idx_d   = win_c;
               ptr_d   = IDX_W'(win_c + IDX_W'(1));
               cnt_d   = CNT_W'(1);
               valid_d = 1'b1;
            end else begin
               idx_d = '0;
               cnt_d = '0;
            end
         end
         GRANT: begin
            if (!own_req_c) begin
               idx_d = '0;
               cnt_d = '0;
            end else if (expire_c) begin
               idx_d     = '0;
               cnt_d     = '0;
               timeout_d = 1'b1;
            end else begin
               valid_d = 1'b1;
               // Without a hold limit the counter parks at 1.
               cnt_d   = HOLD_EN ? CNT_W'(cnt_q + CNT_W'(1)) : CNT_W'(1);
            end
         end
         default: begin
            idx_d = '0;
            cnt_d = '0;
         end
      endcase
   end

   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;
   assign timeout   = timeout_q;

   DMux8Way u_gnt_dec (
      .in  (valid_q),
      .sel (idx_q),
      .a   (gnt[0]),
      .b   (gnt[1]),
      .c   (gnt[2]),
      .d   (gnt[3]),
      .e   (gnt[4]),
      .f   (gnt[5]),
      .g   (gnt[6]),
      .h   (gnt[7])
   );

endmodule

// File: tb/tb_arbiter_8way.sv
// Bench for arbiter_8way: three instances (hold limit 15, 3, 0) on shared inputs,
// directed vector table, hand sequences and random traffic against an owner-level model.
module tb_arbiter_8way;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;

   logic [7:0] gnt_w   [3];
   logic [2:0] idx_w   [3];
   logic       valid_w [3];
   logic       to_w    [3];

   int checks;
   int errors;

   // Reference model state per instance: owner = -1 when idle.
   int m_owner [3];
   int m_hold  [3];
   int m_ptr   [3];
   bit m_to    [3];
   int m_lim   [3];

   typedef struct {
      logic       rst_n;
      logic [7:0] req;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
      logic       to;
   } vec_t;

   vec_t tbl [20];

   arbiter_8way #(.MAX_HOLD(15)) u_a (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt_w[0]), .gnt_idx(idx_w[0]), .gnt_valid(valid_w[0]), .timeout(to_w[0])
   );
   arbiter_8way #(.MAX_HOLD(3)) u_b (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt_w[1]), .gnt_idx(idx_w[1]), .gnt_valid(valid_w[1]), .timeout(to_w[1])
   );
   arbiter_8way #(.MAX_HOLD(0)) u_c (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt_w[2]), .gnt_idx(idx_w[2]), .gnt_valid(valid_w[2]), .timeout(to_w[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_update(input logic [7:0] r, input logic rn);
      for (int d = 0; d < 3; d++) begin
         if (!rn) begin
            m_owner[d] = -1; m_hold[d] = 0; m_ptr[d] = 0; m_to[d] = 0;
         end else if (m_owner[d] < 0) begin
            m_to[d] = 0;
            if (r != 8'h00) begin
               for (int k = 0; k < 8; k++) begin
                  int c;
                  c = (m_ptr[d] + k) % 8;
                  if (m_owner[d] < 0 && r[c]) m_owner[d] = c;
               end
               m_ptr[d]  = (m_owner[d] + 1) % 8;
               m_hold[d] = 1;
            end
         end else if (!r[m_owner[d]]) begin
            m_owner[d] = -1; m_hold[d] = 0; m_to[d] = 0;
         end else if (m_lim[d] != 0 && m_hold[d] == m_lim[d]) begin
            m_owner[d] = -1; m_hold[d] = 0; m_to[d] = 1;
         end else begin
            m_hold[d] = (m_lim[d] == 0) ? 1 : m_hold[d] + 1;
            m_to[d]   = 0;
         end
      end
   endtask

   task automatic model_check();
      for (int d = 0; d < 3; d++) begin
         logic [7:0] eg;
         logic [7:0] ei;
         eg = (m_owner[d] < 0) ? 8'h00 : 8'(1 << m_owner[d]);
         ei = (m_owner[d] < 0) ? 8'h00 : 8'(m_owner[d]);
         chk($sformatf("model[%0d] gnt", d), gnt_w[d], eg);
         chk($sformatf("model[%0d] gnt_idx", d), 8'(idx_w[d]), ei);
         chk($sformatf("model[%0d] gnt_valid", d), 8'(valid_w[d]), 8'(m_owner[d] >= 0));
         chk($sformatf("model[%0d] timeout", d), 8'(to_w[d]), 8'(m_to[d]));
      end
   endtask

   // Apply inputs, clock one edge, then sample outputs 1 time unit later.
   task automatic step(input logic [7:0] r, input logic rn);
      req   = r;
      rst_n = rn;
      @(posedge clk);
      model_update(r, rn);
      #1;
      model_check();
   endtask

   initial begin
      logic [7:0] rr;
      checks = 0;
      errors = 0;
      req    = 8'h00;
      rst_n  = 1'b0;
      m_lim[0] = 15; m_lim[1] = 3; m_lim[2] = 0;
      for (int d = 0; d < 3; d++) begin
         m_owner[d] = -1; m_hold[d] = 0; m_ptr[d] = 0; m_to[d] = 0;
      end

      // rst_n, req -> gnt, idx, valid, timeout (same for all three hold limits)
      tbl[0]  = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
      tbl[16] = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[18] = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0};
      tbl[19] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

      for (int v = 0; v < 20; v++) begin
         step(tbl[v].req, tbl[v].rst_n);
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("vec%0d[%0d] gnt", v, d), gnt_w[d], tbl[v].gnt);
            chk($sformatf("vec%0d[%0d] gnt_idx", v, d), 8'(idx_w[d]), 8'(tbl[v].idx));
            chk($sformatf("vec%0d[%0d] gnt_valid", v, d), 8'(valid_w[d]), 8'(tbl[v].valid));
            chk($sformatf("vec%0d[%0d] timeout", v, d), 8'(to_w[d]), 8'(tbl[v].to));
         end
      end

      // Hold limit 3 with all clients requesting: 0..7,0, each 3 cycles then a timeout cycle.
      step(8'hFF, 1'b0);
      for (int g = 0; g < 9; g++) begin
         for (int c = 0; c < 3; c++) begin
            step(8'hFF, 1'b1);
            chk($sformatf("rr grant%0d cyc%0d gnt", g, c), gnt_w[1], 8'(1 << (g % 8)));
            chk($sformatf("rr grant%0d cyc%0d timeout", g, c), 8'(to_w[1]), 8'h00);
         end
         step(8'hFF, 1'b1);
         chk($sformatf("rr grant%0d revoke gnt", g), gnt_w[1], 8'h00);
         chk($sformatf("rr grant%0d revoke timeout", g), 8'(to_w[1]), 8'h01);
      end

      // No hold limit: a single requester keeps the grant indefinitely.
      step(8'h04, 1'b0);
      for (int c = 0; c < 300; c++) begin
         step(8'h04, 1'b1);
         chk($sformatf("nolimit cyc%0d gnt", c), gnt_w[2], 8'h04);
         chk($sformatf("nolimit cyc%0d timeout", c), 8'(to_w[2]), 8'h00);
      end

      // Random traffic, mostly stable request patterns so hold limits can expire.
      rr = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(7, 0) == 0) rr = 8'($urandom);
         if ($urandom_range(15, 0) == 0) rr = rr & 8'($urandom);
         step(rr, ($urandom_range(99, 0) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
